iq_quant_pack: RTL and testbench
================================

# iq_quant_pack

Parametrised I/Q quantiser and packer for the QPSK RFNoC datapath. It takes one sc16 sample per input beat, reduces I and Q to QBITS each (sign plus selected magnitude bits, optionally saturated) and packs SAMPS_PER_WORD samples into each OUT_WIDTH-bit output word. Packet boundaries are honoured: a partial word is zero-padded and flushed on i_tlast. It sits between the radio/DDC stream and the byte-oriented demod/deframer stage.

## Interface
- IN_WIDTH, 32: input beat; I in [31:16], Q in [15:0], two's complement.
- QBITS, 4: bits kept per component, 2..8.
- LSB_POS, 9: component bit index of the lowest kept magnitude bit; the kept value is {comp[15], comp[LSB_POS+QBITS-2:LSB_POS]}.
- OUT_WIDTH, 32: output word width; must be a multiple of 2*QBITS.
- MSB_FIRST, 1: 1 places the first sample of a word in the top lane; 0 places it in the bottom lane.
- Localparam SAMPS_PER_WORD = OUT_WIDTH/(2*QBITS), default 4. Lane = {Iq, Qq}, Iq in the upper half.
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush: discards the partial word and returns the lane counter to 0.
- i_tdata  in  IN_WIDTH  sample; i_tlast  in  1  end of packet; i_tvalid  in  1; i_tready  out  1.
- o_tdata  out  OUT_WIDTH  packed word; o_tlast  out  1; o_tvalid  out  1; o_tready  in  1.
- o_nsamps  out  $clog2(SAMPS_PER_WORD+1)  number of valid lanes in o_tdata, 1..SAMPS_PER_WORD.

## Operation
- State: lane counter cnt (0..SAMPS_PER_WORD-1), accumulator acc, and an output register holding o_tdata/o_tlast/o_nsamps/o_tvalid.
- Accept = i_tvalid & i_tready. A "closing" beat is one with cnt==SAMPS_PER_WORD-1 or i_tlast=1.
- i_tready = 1 for non-closing beats. For closing beats, i_tready = ~o_tvalid | o_tready.
- Non-closing accept: the quantised lane is written into acc at lane cnt (mirrored when MSB_FIRST=0), and cnt increments.
- Closing accept: the output register loads acc merged with the current lane. Unwritten lanes are forced to 0. o_nsamps = cnt+1, o_tlast = i_tlast, o_tvalid goes to 1. cnt and acc are cleared.
- o_tvalid clears on o_tready when no closing accept occurs in the same cycle. A simultaneous drain and closing accept reloads the output register with o_tvalid held at 1.
- clear has priority over any accept in the same cycle. It does not touch a pending output word.
- The lane counter is not persistent across packets: every packet starts at lane 0.

## Timing
- Reset values: o_tvalid=0, o_tlast=0, o_tdata=0, o_nsamps=0, cnt=0, acc=0. i_tready=1 after reset.
- Latency: the word is visible at o_tdata the cycle after its closing beat is accepted.
- Throughput: one sample per clock at steady state with o_tready=1, i.e. one word every SAMPS_PER_WORD clocks.
- Backpressure: with o_tready=0, up to SAMPS_PER_WORD-1 further samples are accepted, then the closing beat stalls.
- o_tdata, o_tlast and o_nsamps are stable while o_tvalid & ~o_tready.
- Reset asserted mid-word: the partial word is lost and no output is produced.

## Configuration
- IQ_QUANT_PACK_SAT_EN defined: the component saturates when bits [14:LSB_POS+QBITS-1] are not all equal to bit 15. Positive values saturate to {0, all ones}; negative values saturate to {1, all zeros}.
- IQ_QUANT_PACK_SAT_EN undefined: plain bit selection, discarded MSBs are ignored. No extra logic.

## Structure
- A shared package holds the lane typedef, the SAMPS_PER_WORD / count-width derivation functions, and an elaboration check that OUT_WIDTH % (2*QBITS) == 0.
- Sub-module iq_quant_lane: a combinational quantiser for one component (including the saturation option), instantiated twice, for I and Q.

## Test plan
- Defaults: four beats of 32'h0E00_0200 with o_tready=1 -> one word 32'h7171_7171, o_nsamps=4, o_tlast only if the fourth beat has tlast.
- Partial packet: beats 32'h0E00_0200 and 32'hF200_0200, tlast on the second -> 32'h7191_0000, o_nsamps=2, o_tlast=1. The next packet starts at the top lane.
- Saturation: I=16'h7000. With IQ_QUANT_PACK_SAT_EN the lane I nibble is 4'h7; without it the nibble is 4'h0. I=16'hF200 gives 4'h9 in both builds.
- Backpressure: hold o_tready=0 after one word -> three more beats are accepted and i_tready drops on the 4th. Releasing o_tready drains the first word and accepts the 4th in the same cycle, with o_tvalid staying high.
- clear asserted with cnt=2 -> partial data is discarded, and the next four beats form a clean word.
- Asynchronous reset_n pulse mid-word with o_tvalid=1 -> all outputs are at reset values immediately, with no spurious word afterwards.

Source files
------------

// File: rtl/iq_quant_pack_pkg.sv
// -----------------------------------------------------------------------------
// iq_quant_pack_pkg
// Shared types and elaboration helpers for the I/Q quantiser/packer.
//   comp_t         : one sc16 component (two's complement, 16 bits)
//   sc16_t         : one input beat, I in the upper half, Q in the lower half
//   lane_order_e   : placement of the first sample of a word
//   samps_per_word : OUT_WIDTH / (2*QBITS)
//   cnt_width      : lane counter width (at least 1 bit)
//   nsamps_width   : width of o_nsamps, wide enough to hold SAMPS_PER_WORD
//   cfg_ok         : legality check used at elaboration time
// -----------------------------------------------------------------------------
package iq_quant_pack_pkg;

  localparam int unsigned COMP_W    = 16;
  localparam int unsigned QBITS_MIN = 2;
  localparam int unsigned QBITS_MAX = 8;

  typedef logic [COMP_W-1:0] comp_t;

  typedef struct packed {
    comp_t i;
    comp_t q;
  } sc16_t;

  typedef enum logic {
    LANE_ORDER_LSB_FIRST = 1'b0,
    LANE_ORDER_MSB_FIRST = 1'b1
  } lane_order_e;

  function automatic int unsigned samps_per_word(input int unsigned out_w,
                                                 input int unsigned qbits);
    return out_w / (2 * qbits);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned spw);
    return (spw > 1) ? $clog2(spw) : 1;
  endfunction

  function automatic int unsigned nsamps_width(input int unsigned spw);
    return $clog2(spw + 1);
  endfunction

  function automatic bit cfg_ok(input int unsigned in_w,
                                input int unsigned out_w,
                                input int unsigned qbits,
                                input int unsigned lsb_pos);
    bit ok;
    ok = 1'b1;
    if (in_w != 2 * COMP_W)                      ok = 1'b0;
    if (qbits < QBITS_MIN || qbits > QBITS_MAX)  ok = 1'b0;
    if ((out_w % (2 * qbits)) != 0)              ok = 1'b0;
    if (out_w < 2 * qbits)                       ok = 1'b0;
    // Highest kept magnitude bit must sit below the sign bit.
    if (lsb_pos + qbits - 2 > COMP_W - 2)        ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/iq_quant_lane.sv
// -----------------------------------------------------------------------------
// iq_quant_lane
// Combinational quantiser for one sc16 component.
//   comp : 16-bit two's complement component
//   q    : {comp[15], comp[LSB_POS+QBITS-2:LSB_POS]}
// Optional macro IQ_QUANT_PACK_SAT_EN: when the discarded bits
// [14:LSB_POS+QBITS-1] differ from the sign, the result saturates to the
// largest positive ({0,1..1}) or most negative ({1,0..0}) code.
// -----------------------------------------------------------------------------
module iq_quant_lane
  import iq_quant_pack_pkg::*;
#(
  parameter int unsigned QBITS   = 4,
  parameter int unsigned LSB_POS = 9
) (
  input  logic [COMP_W-1:0] comp,
  output logic [QBITS-1:0]  q
);

  // Bits below LSB_POS (and, without saturation, above the kept field) are
  // intentionally dropped.
  logic unused_comp;
  assign unused_comp = ^comp;

`ifdef IQ_QUANT_PACK_SAT_EN
  logic ovf;

  always_comb begin
    ovf = 1'b0;
    for (int unsigned b = LSB_POS + QBITS - 1; b < COMP_W - 1; b++) begin
      if (comp[b] != comp[COMP_W-1]) ovf = 1'b1;
    end
    q = {comp[COMP_W-1], comp[LSB_POS +: QBITS-1]};
    if (ovf) q = {comp[COMP_W-1], {(QBITS-1){~comp[COMP_W-1]}}};
  end
`else
  always_comb begin
    q = {comp[COMP_W-1], comp[LSB_POS +: QBITS-1]};
  end
`endif

endmodule

// File: rtl/iq_quant_pack.sv
// -----------------------------------------------------------------------------
// iq_quant_pack
// Quantises sc16 samples to QBITS per component and packs SAMPS_PER_WORD
// lanes ({Iq,Qq}) into each OUT_WIDTH-bit word. A packet end (i_tlast)
// flushes a partial word, zero-padded, with o_nsamps giving the lane count.
// Optional macro IQ_QUANT_PACK_SAT_EN enables component saturation.
// Ports:
//   clk, reset_n (async, active-low), clear (sync flush of partial word)
//   i_tdata/i_tlast/i_tvalid/i_tready : sample stream in
//   o_tdata/o_tlast/o_tvalid/o_tready : packed word stream out
//   o_nsamps                          : valid lanes in o_tdata
// -----------------------------------------------------------------------------
module iq_quant_pack
  import iq_quant_pack_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned QBITS     = 4,
  parameter int unsigned LSB_POS   = 9,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic [IN_WIDTH-1:0]  i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [OUT_WIDTH-1:0] o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic [nsamps_width(samps_per_word(OUT_WIDTH, QBITS))-1:0] o_nsamps
);

  localparam int unsigned SPW = samps_per_word(OUT_WIDTH, QBITS);
  localparam int unsigned LW  = 2 * QBITS;
  localparam int unsigned CW  = cnt_width(SPW);
  localparam int unsigned NW  = nsamps_width(SPW);
  localparam lane_order_e ORDER = (MSB_FIRST != 0) ? LANE_ORDER_MSB_FIRST
                                                   : LANE_ORDER_LSB_FIRST;

  if (!cfg_ok(IN_WIDTH, OUT_WIDTH, QBITS, LSB_POS)) begin : g_cfg_err
    $error("iq_quant_pack: illegal IN_WIDTH/OUT_WIDTH/QBITS/LSB_POS combination");
  end

  sc16_t            beat;
  logic [QBITS-1:0] iq;
  logic [QBITS-1:0] qq;
  logic [LW-1:0]    lane;

  assign beat = sc16_t'(i_tdata);
  assign lane = {iq, qq};

  iq_quant_lane #(
    .QBITS   (QBITS),
    .LSB_POS (LSB_POS)
  ) u_lane_i (
    .comp (beat.i),
    .q    (iq)
  );

  iq_quant_lane #(
    .QBITS   (QBITS),
    .LSB_POS (LSB_POS)
  ) u_lane_q (
    .comp (beat.q),
    .q    (qq)
  );

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] o_data_q, o_data_d;
  logic                 o_last_q, o_last_d;
  logic                 o_valid_q, o_valid_d;
  logic [NW-1:0]        o_nsamps_q, o_nsamps_d;

  logic                 closing;
  logic                 accept;
  logic [CW-1:0]        pos;
  logic [OUT_WIDTH-1:0] merged;

  // Handshake: only a closing beat needs room in the output register.
  always_comb begin
    closing  = i_tlast | (cnt_q == CW'(SPW - 1));
    i_tready = closing ? (~o_valid_q | o_tready) : 1'b1;
    accept   = i_tvalid & i_tready;
  end

  // acc only ever holds written lanes; everything else is still zero from
  // the last flush, so merging the current lane yields a zero-padded word.
  always_comb begin
    pos    = (ORDER == LANE_ORDER_MSB_FIRST) ? (CW'(SPW - 1) - cnt_q) : cnt_q;
    merged = acc_q;
    for (int unsigned k = 0; k < SPW; k++) begin
      if (CW'(k) == pos) merged[k*LW +: LW] = lane;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    o_data_d   = o_data_q;
    o_last_d   = o_last_q;
    o_valid_d  = o_valid_q;
    o_nsamps_d = o_nsamps_q;

    if (o_valid_q & o_tready) o_valid_d = 1'b0;

    if (clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (accept) begin
      if (closing) begin
        o_data_d   = merged;
        o_last_d   = i_tlast;
        o_valid_d  = 1'b1;
        o_nsamps_d = NW'(cnt_q) + NW'(1);
        cnt_d      = '0;
        acc_d      = '0;
      end else begin
        acc_d = merged;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      o_data_q   <= '0;
      o_last_q   <= 1'b0;
      o_valid_q  <= 1'b0;
      o_nsamps_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      o_data_q   <= o_data_d;
      o_last_q   <= o_last_d;
      o_valid_q  <= o_valid_d;
      o_nsamps_q <= o_nsamps_d;
    end
  end

  assign o_tdata  = o_data_q;
  assign o_tlast  = o_last_q;
  assign o_tvalid = o_valid_q;
  assign o_nsamps = o_nsamps_q;

endmodule

// File: tb/tb_iq_quant_pack.sv
// -----------------------------------------------------------------------------
// tb_iq_quant_pack
// Scoreboard bench for iq_quant_pack with default parameters. Stimulus
// feeds a reference packer (lists of quantised lanes); a monitor pops
// expected words whenever the DUT hands one over.
// -----------------------------------------------------------------------------
module tb_iq_quant_pack;

  localparam int unsigned IN_WIDTH  = 32;
  localparam int unsigned QBITS     = 4;
  localparam int unsigned LSB_POS   = 9;
  localparam int unsigned OUT_WIDTH = 32;
  localparam int unsigned MSB_FIRST = 1;
  localparam int unsigned SPW       = OUT_WIDTH / (2 * QBITS);
  localparam int unsigned LW        = 2 * QBITS;
  localparam int unsigned NW        = $clog2(SPW + 1);

  logic                 clk;
  logic                 reset_n;
  logic                 clear;
  logic [IN_WIDTH-1:0]  i_tdata;
  logic                 i_tlast;
  logic                 i_tvalid;
  logic                 i_tready;
  logic [OUT_WIDTH-1:0] o_tdata;
  logic                 o_tlast;
  logic                 o_tvalid;
  logic                 o_tready;
  logic [NW-1:0]        o_nsamps;

  iq_quant_pack #(
    .IN_WIDTH  (IN_WIDTH),
    .QBITS     (QBITS),
    .LSB_POS   (LSB_POS),
    .OUT_WIDTH (OUT_WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .o_nsamps (o_nsamps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_WIDTH-1:0] data;
    logic                 last;
    int unsigned          nsamps;
  } exp_t;

  exp_t          sb[$];
  logic [LW-1:0] pending[$];
  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  bit            rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference quantiser from the numeric value: saturation happens when the
  // value does not fit in the kept range [-2^(LSB+Q-1), 2^(LSB+Q-1)).
  function automatic logic [QBITS-1:0] quant(input logic [15:0] c);
    int s;
    int lim;
    int mag;
    int sgn;
    s   = $signed(c);
    lim = 1 << (LSB_POS + QBITS - 1);
`ifdef IQ_QUANT_PACK_SAT_EN
    if (s >= lim)  return QBITS'((1 << (QBITS - 1)) - 1);
    if (s < -lim)  return QBITS'(1 << (QBITS - 1));
`endif
    sgn = (s < 0) ? 1 : 0;
    mag = (s >>> LSB_POS) & ((1 << (QBITS - 1)) - 1);
    return QBITS'((sgn << (QBITS - 1)) | mag);
  endfunction

  task automatic model_accept(input logic [31:0] d, input logic l);
    logic [OUT_WIDTH-1:0] w;
    exp_t e;
    pending.push_back({quant(d[31:16]), quant(d[15:0])});
    if (pending.size() == SPW || l) begin
      w = '0;
      for (int j = 0; j < pending.size(); j++) begin
        if (MSB_FIRST != 0) w = w | (OUT_WIDTH'(pending[j]) << (LW * (SPW - 1 - j)));
        else                w = w | (OUT_WIDTH'(pending[j]) << (LW * j));
      end
      e.data   = w;
      e.last   = l;
      e.nsamps = pending.size();
      sb.push_back(e);
      pending.delete();
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int unsigned waitc;
    waitc    = 0;
    i_tdata  = d;
    i_tlast  = l;
    i_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (i_tready) begin
        if (!clear) model_accept(d, l);
        @(posedge clk);
        #1;
        break;
      end
      waitc++;
      if (waitc > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got i_tready=0 for 200 cycles expected accept");
        @(posedge clk);
        #1;
        break;
      end
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    pending.delete();
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Random output backpressure; changes land just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) o_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops and compares on every output handshake, and requires a
  // stalled word to stay put.
  exp_t                 mon_e;
  bit                   hold_valid = 1'b0;
  logic [OUT_WIDTH+NW:0] hold_snap;

  always @(negedge clk) begin
    if (reset_n && o_tvalid) begin
      if (hold_valid) check("hold_stable", 64'({o_tdata, o_tlast, o_nsamps}), 64'(hold_snap));
      if (o_tready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h expected no word", o_tdata);
        end else begin
          mon_e = sb.pop_front();
          check("word_data",   64'(o_tdata),  64'(mon_e.data));
          check("word_last",   64'(o_tlast),  64'(mon_e.last));
          check("word_nsamps", 64'(o_nsamps), 64'(mon_e.nsamps));
        end
        hold_valid = 1'b0;
      end else begin
        hold_valid = 1'b1;
        hold_snap  = {o_tdata, o_tlast, o_nsamps};
      end
    end else begin
      hold_valid = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] edge_vals [8];
  logic [31:0] d;
  logic        l;
  int unsigned waitc;

  initial begin
    edge_vals = '{16'h0FFF, 16'h1000, 16'hF000, 16'hEFFF,
                  16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
    reset_n  = 1'b0;
    clear    = 1'b0;
    i_tdata  = '0;
    i_tlast  = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_tvalid", 64'(o_tvalid), 64'd0);
    check("rst_tlast",  64'(o_tlast),  64'd0);
    check("rst_tdata",  64'(o_tdata),  64'd0);
    check("rst_nsamps", 64'(o_nsamps), 64'd0);
    check("rst_tready", 64'(i_tready), 64'd1);

    // Full word, visible the cycle after the closing beat
    for (int i = 0; i < 4; i++) send(32'h0E00_0200, (i == 3));
    check("full_valid",  64'(o_tvalid), 64'd1);
    check("full_data",   64'(o_tdata),  64'h7171_7171);
    check("full_nsamps", 64'(o_nsamps), 64'd4);
    check("full_last",   64'(o_tlast),  64'd1);
    for (int i = 0; i < 4; i++) send(32'h0E00_0200, 1'b0);
    check("full_nolast", 64'(o_tlast),  64'd0);
    idle(2);

    // Partial packet, then next packet starts at top lane
    send(32'h0E00_0200, 1'b0);
    send(32'hF200_0200, 1'b1);
    check("part_data",   64'(o_tdata),  64'h7191_0000);
    check("part_nsamps", 64'(o_nsamps), 64'd2);
    check("part_last",   64'(o_tlast),  64'd1);
    send(32'h0E00_0200, 1'b1);
    check("next_pkt_top", 64'(o_tdata), 64'h7100_0000);
    check("next_pkt_n",   64'(o_nsamps), 64'd1);
    idle(2);

    // Saturation boundary
    send(32'h7000_0200, 1'b1);
`ifdef IQ_QUANT_PACK_SAT_EN
    check("sat_pos_nib", 64'(o_tdata[31:28]), 64'h7);
`else
    check("sat_pos_nib", 64'(o_tdata[31:28]), 64'h0);
`endif
    send(32'hF200_0200, 1'b1);
    check("neg_nib", 64'(o_tdata[31:28]), 64'h9);
    idle(2);

    // Backpressure: one word parked, three more accepted, fourth stalls
    o_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h0E00_0200, 1'b0);
    for (int i = 0; i < 3; i++) send($urandom, 1'b0);
    check("bp_word_parked", 64'(o_tvalid), 64'd1);
    d        = $urandom;
    i_tdata  = d;
    i_tlast  = 1'b0;
    i_tvalid = 1'b1;
    @(negedge clk);
    check("bp_stall", 64'(i_tready), 64'd0);
    @(posedge clk);
    #1;
    o_tready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(i_tready), 64'd1);
    if (i_tready) model_accept(d, 1'b0);
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
    check("bp_valid_held", 64'(o_tvalid), 64'd1);
    idle(3);

    // clear at cnt=2, with a beat offered in the same cycle
    send(32'h1234_5678, 1'b0);
    send(32'h8765_4321, 1'b0);
    clear = 1'b1;
    send(32'hAAAA_5555, 1'b0);
    clear = 1'b0;
    pending.delete();
    for (int i = 0; i < 4; i++) send(32'h0E00_0200, 1'b0);
    check("clear_clean_word", 64'(o_tdata),  64'h7171_7171);
    check("clear_clean_n",    64'(o_nsamps), 64'd4);
    idle(2);

    // Asynchronous reset mid-word while a word is parked
    o_tready = 1'b0;
    for (int i = 0; i < 4; i++) send($urandom, 1'b0);
    send($urandom, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_tvalid", 64'(o_tvalid), 64'd0);
    check("arst_tdata",  64'(o_tdata),  64'd0);
    check("arst_tlast",  64'(o_tlast),  64'd0);
    check("arst_nsamps", 64'(o_nsamps), 64'd0);
    sb.delete();
    pending.delete();
    #3;
    reset_n  = 1'b1;
    o_tready = 1'b1;
    idle(6);
    check("arst_no_word", 64'(o_tvalid), 64'd0);

    // Randomised traffic with backpressure, idles and occasional clears
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        d = {edge_vals[$urandom_range(0, 7)], edge_vals[$urandom_range(0, 7)]};
      else
        d = $urandom;
      l = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 29) == 0) do_clear();
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      send(d, l);
    end
    send($urandom, 1'b1);

    @(negedge clk);
    #2;
    rand_ready = 1'b0;
    o_tready   = 1'b1;
    waitc = 0;
    while (sb.size() != 0 && waitc < 50) begin
      @(posedge clk);
      waitc++;
    end
    idle(2);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
